// File: rtl/exec_datapath.sv
// exec_datapath: execute/writeback stage with an 8x16 register file, a single-cycle ALU and
// an iterative restoring divider that stalls the sequencer through busy_o.
module exec_datapath #(
  parameter int WIDTH      = 16,
  parameter int NREGS      = 8,
  parameter int DIV_CYCLES = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rf_write_i,
  input  logic [3:0]               alu_sel_i,
  input  logic                     imm_sel_i,
  input  logic [$clog2(NREGS)-1:0] rs_addr_i,
  input  logic [$clog2(NREGS)-1:0] rt_addr_i,
  input  logic [$clog2(NREGS)-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]         imm_data_i,
  output logic                     zero_flag_o,
  output logic                     pos_flag_o,
  output logic                     busy_o,
  input  logic [$clog2(NREGS)-1:0] dbg_addr_i,
  output logic [WIDTH-1:0]         dbg_data_o
);
  localparam int AW = $clog2(NREGS);
  localparam int CW = $clog2(DIV_CYCLES);
  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_DIV = 4'd5;
  localparam logic [3:0] OP_CMP = 4'd11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] rf_q [NREGS];
  logic             zero_q, pos_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [AW-1:0]    rd_q;

  logic [WIDTH-1:0] op_a, op_b, res;
  logic             shift_oor;
  logic [WIDTH:0]   part;
  logic             ge;
  logic [WIDTH-1:0] rem_d, quo_d;

  function automatic logic [1:0] flags(input logic [WIDTH-1:0] r);
    return {r == '0, r != '0 && !r[WIDTH-1]};
  endfunction

  assign op_a      = rf_q[rs_addr_i];
  assign op_b      = imm_sel_i ? imm_data_i : rf_q[rt_addr_i];
  assign shift_oor = op_b > WIDTH'(WIDTH - 1);

  always_comb begin
    res = '0;
    case (alu_sel_i)
      4'd0:    res = op_a;
      4'd1:    res = imm_data_i;
      4'd2:    res = op_a + op_b;
      4'd3:    res = op_a - op_b;
      4'd4:    res = op_a * op_b;
      4'd6:    res = op_a & op_b;
      4'd7:    res = op_a | op_b;
      4'd8:    res = op_a ^ op_b;
      4'd9:    res = shift_oor ? '0 : op_a << op_b[SW-1:0];
      4'd10:   res = shift_oor ? '0 : op_a >> op_b[SW-1:0];
      4'd11:   res = op_a - op_b;
      default: res = '0;
    endcase
  end

  // Restoring step: the dividend shifts out of quo_q while quotient bits shift in.
  // A zero divisor always "fits", which yields the all-ones quotient for free.
  assign part  = {rem_q, quo_q[WIDTH-1]};
  assign ge    = part >= {1'b0, dvs_q};
  assign rem_d = ge ? WIDTH'(part - {1'b0, dvs_q}) : part[WIDTH-1:0];
  assign quo_d = {quo_q[WIDTH-2:0], ge};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      zero_q  <= 1'b0;
      pos_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rd_q    <= '0;
    end else if (state_q == IDLE) begin
      if (rf_write_i && alu_sel_i == OP_DIV) begin
        state_q <= RUN;
        cnt_q   <= '0;
        rem_q   <= '0;
        quo_q   <= op_a;
        dvs_q   <= op_b;
        rd_q    <= rd_addr_i;
      end else if (rf_write_i && alu_sel_i <= OP_CMP) begin
        if (alu_sel_i != OP_CMP) rf_q[rd_addr_i] <= res;
        {zero_q, pos_q} <= flags(res);
      end
    end else if (state_q == RUN) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(DIV_CYCLES - 1)) state_q <= DONE;
    end else begin
      rf_q[rd_q]      <= quo_q;
      {zero_q, pos_q} <= flags(quo_q);
      state_q         <= IDLE;
    end
  end

  assign zero_flag_o = zero_q;
  assign pos_flag_o  = pos_q;
  assign busy_o      = state_q != IDLE;
  assign dbg_data_o  = rf_q[dbg_addr_i];
endmodule
